// File: rtl/hdlc_tx_framer_if.sv
`timescale 1ns / 1ps
// hdlc_tx_framer_if
// Byte-load handshake between a payload source and the HDLC transmit framer.
//   dat_i   : payload byte, sent LSB first
//   valid_i : dat_i / last_i are valid
//   last_i  : dat_i is the final payload byte of the frame
//   ready_o : byte-load strobe from the framer; a byte moves when valid_i & ready_o
// The master modport is the payload source; the slave modport is the framer.
interface hdlc_tx_framer_if;
  logic [7:0] dat_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;

  modport master (
    output dat_i,
    output valid_i,
    output last_i,
    input  ready_o
  );

  modport slave (
    input  dat_i,
    input  valid_i,
    input  last_i,
    output ready_o
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
`timescale 1ns / 1ps
// hdlc_tx_framer
// Serialises payload bytes into an HDLC frame: opening flag 0x7E, bit-stuffed payload
// (a 0 inserted after every five consecutive 1s), closing flag 0x7E. An abort sequence
// (0xFE, LSB first) replaces the rest of the frame on abort request or payload underrun.
// One line bit advances per clk_i cycle in which txen is high; nothing moves otherwise.
//
// Ports
//   clk_i      : clock, all state changes on the rising edge
//   rst_i      : synchronous active-high reset
//   txen       : bit strobe
//   frame      : frame request, a 0->1 transition (seen in txen cycles) starts a frame
//   abortframe : abort the frame in progress (opening flag or payload only)
//   byte_if    : payload byte handshake (slave side)
//   tx         : registered serial line, IDLE_BIT outside a frame
//   txdone     : one-cycle pulse once the closing flag's last bit is on the line
//   underrun_o : one-cycle pulse when a byte was needed but valid_i was low
//   busy_o     : high whenever a frame or abort sequence is in progress
module hdlc_tx_framer #(
  parameter bit IDLE_BIT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            txen,
  input  logic            frame,
  input  logic            abortframe,
  hdlc_tx_framer_if.slave byte_if,
  output logic            tx,
  output logic            txdone,
  output logic            underrun_o,
  output logic            busy_o
);

  localparam logic [7:0] FlagByte  = 8'h7E;
  localparam logic [7:0] AbortByte = 8'hFE;
  localparam logic [2:0] StuffRun  = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StOpenFlag,
    StData,
    StCloseFlag,
    StAbort
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;        // bit index within flag/abort byte or payload byte
  logic [7:0] sr_q, sr_d;          // payload shift register, bit 0 goes out next
  logic       last_q, last_d;      // byte in sr_q is the final payload byte
  logic       tail_q, tail_d;      // final byte fully sent, only its owed stuff bit remains
  logic [2:0] ones_q, ones_d;      // consecutive payload 1s on the line
  logic       frame_low_q, frame_low_d;  // previous txen-cycle sample of frame was 0
  logic       tx_q, tx_d;
  logic       txdone_q, txdone_d;
  logic       underrun_q, underrun_d;
  logic       ready;
  logic       stuff_now;
  logic [2:0] ones_inc;

  assign stuff_now = (ones_q == StuffRun);
  assign ones_inc  = sr_q[0] ? (ones_q + 3'd1) : 3'd0;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    last_d      = last_q;
    tail_d      = tail_q;
    ones_d      = ones_q;
    frame_low_d = frame_low_q;
    tx_d        = tx_q;
    txdone_d    = 1'b0;
    underrun_d  = 1'b0;
    ready       = 1'b0;

    if (txen) begin
      frame_low_d = ~frame;
      unique case (state_q)
        StIdle: begin
          tx_d = IDLE_BIT;
          if (frame && frame_low_q && !abortframe) begin
            state_d = StOpenFlag;
            idx_d   = 3'd0;
          end
        end

        StOpenFlag: begin
          tx_d  = FlagByte[idx_q];
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            ready = 1'b1;
            if (byte_if.valid_i) begin
              sr_d    = byte_if.dat_i;
              last_d  = byte_if.last_i;
              ones_d  = 3'd0;
              tail_d  = 1'b0;
              state_d = StData;
            end else begin
              underrun_d = 1'b1;
              state_d    = StAbort;
            end
          end
          if (abortframe) begin
            state_d = StAbort;
            idx_d   = 3'd0;
          end
        end

        StData: begin
          if (stuff_now) begin
            // Inserted zero: consumes no payload bit and restarts the run.
            tx_d   = 1'b0;
            ones_d = 3'd0;
            if (tail_q) begin
              state_d = StCloseFlag;
              idx_d   = 3'd0;
            end
          end else begin
            tx_d   = sr_q[0];
            sr_d   = {1'b0, sr_q[7:1]};
            ones_d = ones_inc;
            idx_d  = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              if (last_q) begin
                // A run of five ending the payload still owes its stuff bit.
                if (ones_inc == StuffRun) begin
                  tail_d = 1'b1;
                end else begin
                  state_d = StCloseFlag;
                  idx_d   = 3'd0;
                end
              end else begin
                ready = 1'b1;
                if (byte_if.valid_i) begin
                  sr_d   = byte_if.dat_i;
                  last_d = byte_if.last_i;
                end else begin
                  underrun_d = 1'b1;
                  state_d    = StAbort;
                  idx_d      = 3'd0;
                end
              end
            end
          end
          if (abortframe) begin
            state_d = StAbort;
            idx_d   = 3'd0;
          end
        end

        StCloseFlag: begin
          tx_d  = FlagByte[idx_q];
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d  = StIdle;
            txdone_d = 1'b1;
          end
        end

        StAbort: begin
          tx_d  = AbortByte[idx_q];
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
          tx_d    = IDLE_BIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= 3'd0;
      sr_q        <= 8'd0;
      last_q      <= 1'b0;
      tail_q      <= 1'b0;
      ones_q      <= 3'd0;
      // Cleared so a frame level already high at reset release is not taken as an edge.
      frame_low_q <= 1'b0;
      tx_q        <= IDLE_BIT;
      txdone_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      last_q      <= last_d;
      tail_q      <= tail_d;
      ones_q      <= ones_d;
      frame_low_q <= frame_low_d;
      tx_q        <= tx_d;
      txdone_q    <= txdone_d;
      underrun_q  <= underrun_d;
    end
  end

  assign byte_if.ready_o = ready & ~rst_i;
  assign tx              = tx_q;
  assign txdone          = txdone_q;
  assign underrun_o      = underrun_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_hdlc_tx_framer.sv
`timescale 1ns / 1ps
// Randomised self-checking bench for hdlc_tx_framer. Expected line bits come from a
// frame model built as a bit list: flag, stuffed payload, closing flag or abort byte.
module tb_hdlc_tx_framer;
  localparam bit IdleBit = 1'b1;

  logic clk = 1'b0;
  logic rst;
  logic txen;
  logic frame;
  logic abortframe;
  logic tx;
  logic txdone;
  logic underrun;
  logic busy;

  hdlc_tx_framer_if byte_if ();

  hdlc_tx_framer #(
    .IDLE_BIT(IdleBit)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .txen      (txen),
    .frame     (frame),
    .abortframe(abortframe),
    .byte_if   (byte_if),
    .tx        (tx),
    .txdone    (txdone),
    .underrun_o(underrun),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Frame description
  logic [7:0] fr_bytes [8];
  int         fr_n;
  int         fr_under;   // index of the byte that is not available, -1 for none
  int         fr_abort;   // line-bit index during which abortframe is raised, -1 for none
  int         txen_pct;

  // Model results
  bit exp_q[$];
  int ready_pos[$];
  int abortable_len;
  bit closed_exp;
  bit under_exp;
  int ready_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_model();
    logic [7:0] flag = 8'h7E;
    logic [7:0] abt  = 8'hFE;
    int  ones = 0;
    int  nsent;
    bit  normal;
    exp_q.delete();
    ready_pos.delete();
    normal = (fr_under < 0);
    nsent  = normal ? fr_n : fr_under;
    for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
    ready_pos.push_back(7);
    for (int b = 0; b < nsent; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (ones == 5) begin
          exp_q.push_back(1'b0);
          ones = 0;
        end
        exp_q.push_back(fr_bytes[b][i]);
        ones = fr_bytes[b][i] ? ones + 1 : 0;
      end
      if (!normal || b < fr_n - 1) ready_pos.push_back(exp_q.size() - 1);
    end
    if (normal && ones == 5) exp_q.push_back(1'b0);
    abortable_len = exp_q.size();
    closed_exp = normal;
    under_exp  = !normal;
    ready_exp  = ready_pos.size();
    if (fr_abort >= 0 && fr_abort < abortable_len) begin
      while (exp_q.size() > fr_abort + 1) void'(exp_q.pop_back());
      closed_exp = 1'b0;
      under_exp  = !normal && (fr_abort == abortable_len - 1);
      ready_exp  = 0;
      foreach (ready_pos[k]) if (ready_pos[k] <= fr_abort) ready_exp++;
    end
    if (closed_exp) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back(abt[i]);
    end
  endtask

  task automatic drive_source(input int idx);
    if ((fr_under >= 0 && idx >= fr_under) || idx >= fr_n) begin
      byte_if.valid_i = 1'b0;
      byte_if.dat_i   = 8'($urandom);
      byte_if.last_i  = 1'($urandom_range(0, 1));
    end else begin
      byte_if.valid_i = 1'b1;
      byte_if.dat_i   = fr_bytes[idx];
      byte_if.last_i  = (idx == fr_n - 1);
    end
  endtask

  // Runs one frame against the model; stop_at >= 0 leaves the frame mid-flight.
  task automatic run_frame(input int stop_at);
    int   nbits     = 0;
    int   cyc       = 0;
    int   ready_cnt = 0;
    int   done_cnt  = 0;
    int   und_cnt   = 0;
    int   src_idx   = 0;
    bit   xfer;
    logic prev_tx;
    drive_source(src_idx);
    @(negedge clk);
    frame = 1'b0; txen = 1'b1; abortframe = 1'b0;
    @(negedge clk);
    frame = 1'b1; txen = 1'b1;
    @(posedge clk); #1;
    check_eq("start_busy", 32'(busy), 32'(1));
    check_eq("start_tx_idle", 32'(tx), 32'(IdleBit));
    while (nbits < exp_q.size() && cyc < 5000 && nbits != stop_at) begin
      @(negedge clk);
      txen = ($urandom_range(0, 99) < txen_pct);
      abortframe = 1'b0;
      if (txen && nbits == fr_abort) abortframe = 1'b1;
      else if (txen && closed_exp && nbits >= abortable_len)
        abortframe = 1'($urandom_range(0, 1));
      #1;
      if (byte_if.ready_o) ready_cnt++;
      xfer    = byte_if.ready_o && byte_if.valid_i && txen;
      prev_tx = tx;
      @(posedge clk); #1;
      if (txdone) done_cnt++;
      if (underrun) und_cnt++;
      if (txen) begin
        check_eq($sformatf("tx_bit%0d", nbits), 32'(tx), 32'(exp_q[nbits]));
        nbits++;
      end else begin
        check_eq("tx_hold", 32'(tx), 32'(prev_tx));
      end
      if (xfer) begin
        src_idx++;
        drive_source(src_idx);
      end
      cyc++;
    end
    if (stop_at < 0) begin
      check_eq("bits_done", 32'(nbits), 32'(exp_q.size()));
      // frame held high first: no restart without a fresh edge
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        txen = 1'b1;
        abortframe = 1'($urandom_range(0, 1));
        frame = (i < 3);
        @(posedge clk); #1;
        if (txdone) done_cnt++;
        if (underrun) und_cnt++;
        check_eq("idle_busy", 32'(busy), 32'(0));
        check_eq("idle_tx", 32'(tx), 32'(IdleBit));
      end
      abortframe = 1'b0;
      check_eq("txdone_cnt", 32'(done_cnt), 32'(closed_exp));
      check_eq("underrun_cnt", 32'(und_cnt), 32'(under_exp));
      check_eq("ready_cnt", 32'(ready_cnt), 32'(ready_exp));
    end
  endtask

  task automatic set_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input int under, input int abrt, input int pct);
    fr_n = n; fr_bytes[0] = b0; fr_bytes[1] = b1;
    fr_under = under; fr_abort = abrt; txen_pct = pct;
    build_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; txen = 1'b0; frame = 1'b1; abortframe = 1'b0;
    byte_if.valid_i = 1'b0; byte_if.dat_i = 8'h00; byte_if.last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", 32'(tx), 32'(IdleBit));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_txdone", 32'(txdone), 32'(0));
    check_eq("rst_underrun", 32'(underrun), 32'(0));
    check_eq("rst_ready", 32'(byte_if.ready_o), 32'(0));
    @(negedge clk);
    rst = 1'b0; txen = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("no_start_high_after_rst", 32'(busy), 32'(0));
    end

    // Directed frames
    set_frame(1, 8'h55, 8'h00, -1, -1, 100); run_frame(-1);
    set_frame(1, 8'hFF, 8'h00, -1, -1, 100); run_frame(-1);
    set_frame(1, 8'h1F, 8'h00, -1, -1, 100); run_frame(-1);
    set_frame(2, 8'hA5, 8'h3C, 1, -1, 100);  run_frame(-1);
    set_frame(2, 8'h0F, 8'hF0, -1, 12, 100); run_frame(-1);
    set_frame(1, 8'h7E, 8'h00, 0, 7, 100);   run_frame(-1);

    // Randomised frames
    for (int f = 0; f < 40; f++) begin
      fr_n = int'($urandom_range(1, 4));
      for (int b = 0; b < fr_n; b++) begin
        case ($urandom_range(0, 3))
          0:       fr_bytes[b] = 8'hFF;
          1:       fr_bytes[b] = 8'h1F;
          2:       fr_bytes[b] = 8'hF8;
          default: fr_bytes[b] = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 4) == 0) fr_under = int'($urandom_range(0, fr_n - 1));
      else fr_under = -1;
      fr_abort = -1;
      build_model();
      if ($urandom_range(0, 3) == 0) begin
        fr_abort = int'($urandom_range(0, abortable_len - 1));
        build_model();
      end
      if ($urandom_range(0, 1) == 1) txen_pct = 100;
      else txen_pct = int'($urandom_range(40, 90));
      run_frame(-1);
    end

    // Reset in the middle of the payload with a 50% bit strobe
    set_frame(2, 8'hFF, 8'hFF, -1, -1, 50);
    run_frame(14);
    @(negedge clk);
    rst = 1'b1; txen = 1'($urandom_range(0, 1)); abortframe = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_tx", 32'(tx), 32'(IdleBit));
    check_eq("midrst_busy", 32'(busy), 32'(0));
    check_eq("midrst_txdone", 32'(txdone), 32'(0));
    check_eq("midrst_underrun", 32'(underrun), 32'(0));
    @(negedge clk);
    rst = 1'b0; txen = 1'b1;
    #1;
    check_eq("midrst_ready", 32'(byte_if.ready_o), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("midrst_stay_idle", 32'(busy), 32'(0));
      check_eq("midrst_no_txdone", 32'(txdone), 32'(0));
      @(negedge clk);
      txen = 1'($urandom_range(0, 1));
    end
    set_frame(1, 8'h55, 8'h00, -1, -1, 70); run_frame(-1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hdlc_tx_framer.md
HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

Interface
REQ-001 Parameter: IDLE_BIT, default 1, line level driven on tx while no frame is in progress.
REQ-002 clk_i  input  1  single block clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 txen  input  1  bit strobe; one tx bit advances per clk_i cycle with txen=1.
REQ-005 frame  input  1  frame request; a 0->1 transition starts a frame.
REQ-006 abortframe  input  1  abort request for the current frame.
REQ-007 dat_i  input  8  payload byte, transmitted LSB first.
REQ-008 valid_i  input  1  dat_i/last_i valid.
REQ-009 last_i  input  1  qualifies dat_i as final payload byte.
REQ-010 ready_o  output  1  byte-load strobe; transfer = valid_i & ready_o.
REQ-011 tx  output  1  registered serial line.
REQ-012 txdone  output  1  one-cycle pulse after closing flag's last bit.
REQ-013 underrun_o  output  1  one-cycle pulse when a byte was required but valid_i=0.
REQ-014 busy_o  output  1  high in every state except IDLE.

Function
REQ-015 States SHALL be IDLE, OPEN_FLAG, DATA, CLOSE_FLAG, ABORT; all transitions and bit advances occur only in cycles with txen=1, except reset.
REQ-016 IDLE: tx=IDLE_BIT; frame sampled 1 after 0 (previous-sample register) with abortframe=0 and txen=1 at edge N -> OPEN_FLAG, bit index 0.
REQ-017 tx SHALL be registered so the first flag bit (0) is sampled on tx at edge N+2, giving 0,1,1,1,1,1,1,0 at edges N+2..N+9 when txen=1 continuously.
REQ-018 OPEN_FLAG and CLOSE_FLAG emit 0x7E LSB first; flag bits never stuffed and never counted toward stuffing.
REQ-019 ready_o SHALL be high only in the txen=1 cycle in which the last bit (index 7) of OPEN_FLAG or of a data byte is being loaded into tx, no stuff bit being pending.
REQ-020 In that cycle, valid_i=1 loads dat_i/last_i into the shift register and DATA begins next bit; valid_i=0 after OPEN_FLAG or after a non-last byte -> underrun_o pulse, go to ABORT.
REQ-021 After a byte marked last_i completes (including any trailing stuff bit), go to CLOSE_FLAG; ready_o stays 0.
REQ-022 Stuffing: 3-bit ones counter cleared entering DATA and on every 0 transmitted; after five consecutive 1s, the next bit is an inserted 0 not consuming payload; counter then clears.
REQ-023 A stuff bit owed after the final payload bit SHALL be sent before CLOSE_FLAG.
REQ-024 CLOSE_FLAG completion: txdone pulses 1 cycle, go to IDLE; a new rising frame needs a fresh 0->1 edge after that.
REQ-025 abortframe=1 in OPEN_FLAG or DATA: current bit completes, then ABORT; in CLOSE_FLAG or IDLE it is ignored.
REQ-026 ABORT emits 0 then seven 1s (0xFE LSB first), no stuffing, then IDLE; txdone stays 0.
REQ-027 Simultaneous underrun and abortframe: single ABORT, underrun_o still pulses.
REQ-028 txen=0: tx, state, counters, ready_o=0 all hold.

Reset
REQ-029 rst_i=1 at any edge: state IDLE, tx=IDLE_BIT, ready_o=0, txdone=0, underrun_o=0, busy_o=0, counters and frame-edge register cleared, including mid-frame.
REQ-030 After reset, frame already high SHALL not start a frame until it goes low then high.

Verification
REQ-031 txen=1, frame rises at edge N, byte 0x55 last -> tx from N+2: 01111110, 10101010, 01111110; txdone one pulse; ready_o exactly one pulse.
REQ-032 Byte 0xFF last -> data bits 11111 0 111, then 01111110; stuff 0 after fifth 1.
REQ-033 Byte 0x1F last -> 11111 0 000 (stuff after final run), then closing flag.
REQ-034 Two bytes, valid_i=0 at second ready_o -> underrun_o pulse, tx 0 then 1111111, IDLE, no txdone.
REQ-035 abortframe raised mid-byte -> bit completes, 01111111 follows, no txdone.
REQ-036 rst_i pulsed mid-DATA, txen toggling 50% -> tx=1 next cycle, busy_o=0, no txdone; bits hold during txen=0.
